// File: rtl/elixirchip_es1_spu_op_logic.sv
// elixirchip_es1_spu_op_logic: multi-lane eight-function bitwise logic unit with a cke-gated hold pipeline
module elixirchip_es1_spu_op_logic #(
   parameter int    LATENCY         = 1,
   parameter int    DATA_BITS       = 8,
   parameter int    LANES           = 1,
   parameter type   data_t          = logic [DATA_BITS-1:0],
   parameter data_t CLEAR_DATA      = '1,
   parameter bit    IMMEDIATE_DATA0 = 1'b0,
   parameter bit    IMMEDIATE_DATA1 = 1'b0,
   parameter data_t IMM_VALUE0      = '0,
   parameter data_t IMM_VALUE1      = '0,
   parameter string DEVICE          = "RTL",
   parameter string SIMULATION      = "false",
   parameter string DEBUG           = "false"
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       cke,
   input  logic [2:0]                 s_op,
   input  logic [LANES*DATA_BITS-1:0] s_data0,
   input  logic [LANES*DATA_BITS-1:0] s_data1,
   input  logic                       s_clear,
   input  logic                       s_valid,
   output logic [LANES*DATA_BITS-1:0] m_data,
   output logic                       m_valid
);
   localparam int w = LANES*DATA_BITS;
   localparam logic [w-1:0] clr = {LANES{CLEAR_DATA}};
   logic [w-1:0]       res;
   logic [w-1:0]       data_d [LATENCY];
   logic [w-1:0]       data_q [LATENCY];
   logic [LATENCY-1:0] valid_d, valid_q;
   if (LATENCY < 1) begin : g_bad_latency
      $error("LATENCY must be >= 1");
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      data_t a, b;
      assign a = IMMEDIATE_DATA0 ? IMM_VALUE0 : s_data0[i*DATA_BITS +: DATA_BITS];
      assign b = IMMEDIATE_DATA1 ? IMM_VALUE1 : s_data1[i*DATA_BITS +: DATA_BITS];
      assign res[i*DATA_BITS +: DATA_BITS] =
         s_op == 3'd0 ?   a & b  :
         s_op == 3'd1 ?   a | b  :
         s_op == 3'd2 ?   a ^ b  :
         s_op == 3'd3 ? ~(a ^ b) :
         s_op == 3'd4 ? ~(a & b) :
         s_op == 3'd5 ? ~(a | b) :
         s_op == 3'd6 ?   a & ~b :
                          a | ~b;
   end
   always_comb begin
      data_d[0]  = s_clear ? clr : s_valid ? res : data_q[0];
      valid_d[0] = s_valid & ~s_clear;
      for (int k = 1; k < LATENCY; k++) begin
         data_d[k]  = data_q[k-1];
         valid_d[k] = valid_q[k-1];
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < LATENCY; k++) data_q[k] <= clr;
         valid_q <= '0;
      end else if (cke) begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end
   assign m_data  = data_q[LATENCY-1];
   assign m_valid = valid_q[LATENCY-1];
   if (SIMULATION == "true" || DEBUG == "true") begin : g_chk
      always_ff @(posedge clk) begin
         if (reset_n && cke && s_valid && !s_clear)
            assert (!$isunknown(s_op)) else $error("%s: s_op unknown while loading a result", DEVICE);
      end
   end
endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// tb_elixirchip_es1_spu_op_logic: directed bench with a queue-based reference model and literal checks
module tb_elixirchip_es1_spu_op_logic;
   logic        clk = 1'b0;
   logic        reset_n, cke, s_clear, s_valid;
   logic [2:0]  s_op;
   logic [31:0] d0a, d0b, m0;
   logic [15:0] d1a, d1b, m1;
   logic        m0v, m1v;
   int          pass_cnt = 0;
   int          tot_cnt = 0;
   bit          mdl_ok = 1'b0;
   typedef struct packed {logic [31:0] d; logic v;} ent_t;
   ent_t        q0[$], q1[$];
   logic [31:0] s1_0, s1_1, e0d, e1d;
   logic        e0v, e1v;
   logic [7:0]  ev [8] = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'hA0, 8'hF5};

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_logic #(
      .LATENCY(3), .DATA_BITS(8), .LANES(4), .SIMULATION("true")
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_op(s_op), .s_data0(d0a), .s_data1(d0b),
      .s_clear(s_clear), .s_valid(s_valid), .m_data(m0), .m_valid(m0v)
   );

   elixirchip_es1_spu_op_logic #(
      .LATENCY(1), .DATA_BITS(8), .LANES(2), .CLEAR_DATA(8'h3C),
      .IMMEDIATE_DATA1(1'b1), .IMM_VALUE1(8'h0F)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_op(s_op), .s_data0(d1a), .s_data1(d1b),
      .s_clear(s_clear), .s_valid(s_valid), .m_data(m1), .m_valid(m1v)
   );

   function automatic logic [7:0] lf(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a ^ b);
         3'd4: return ~(a & b);
         3'd5: return ~(a | b);
         3'd6: return a & ~b;
         3'd7: return a | ~b;
         default: return 'x;
      endcase
   endfunction

   function automatic logic [31:0] fl(int n, logic [2:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[i*8 +: 8] = lf(op, a[i*8 +: 8], b[i*8 +: 8]);
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Reference model: every enabled edge produces one stage-1 value; output is the one from LATENCY edges back.
   always @(posedge clk) begin
      if (!reset_n) begin
         q0.delete();
         q1.delete();
         s1_0 = 32'hFFFF_FFFF;
         s1_1 = 32'h0000_3C3C;
         mdl_ok = 1'b1;
      end else if (cke) begin
         if (s_clear) begin
            s1_0 = 32'hFFFF_FFFF;
            s1_1 = 32'h0000_3C3C;
         end else if (s_valid) begin
            s1_0 = fl(4, s_op, d0a, d0b);
            s1_1 = fl(2, s_op, {16'h0, d1a}, 32'h0000_0F0F);
         end
         q0.push_back('{s1_0, s_valid && !s_clear});
         q1.push_back('{s1_1, s_valid && !s_clear});
         if (q0.size() > 3) void'(q0.pop_front());
         if (q1.size() > 1) void'(q1.pop_front());
      end
      e0d = q0.size() == 3 ? q0[0].d : 32'hFFFF_FFFF;
      e0v = q0.size() == 3 && q0[0].v;
      e1d = q1.size() == 1 ? q1[0].d : 32'h0000_3C3C;
      e1v = q1.size() == 1 && q1[0].v;
   end

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("m_data0", m0, e0d);
         chk("m_valid0", {31'h0, m0v}, {31'h0, e0v});
         chk("m_data1", {16'h0, m1}, e1d);
         chk("m_valid1", {31'h0, m1v}, {31'h0, e1v});
      end
   end

   initial begin
      reset_n = 1'b0; cke = 1'b1; s_clear = 1'b0; s_valid = 1'b0; s_op = 3'd0;
      d0a = '0; d0b = '0; d1a = '0; d1b = 'x;
      cyc(); cyc();
      chk("rst_data0", m0, 32'hFFFF_FFFF);
      chk("rst_valid0", {31'h0, m0v}, 32'h0);
      chk("rst_data1", {16'h0, m1}, 32'h0000_3C3C);
      reset_n = 1'b1;
      s_valid = 1'b1; d0a = 32'hA5A5_A5A5; d0b = 32'h0F0F_0F0F; d1a = 16'hA5A5;
      for (int i = 0; i < 8; i++) begin
         s_op = 3'(i);
         cyc();
         chk("sweep_data1", {16'h0, m1}, {16'h0, ev[i], ev[i]});
         chk("sweep_valid1", {31'h0, m1v}, 32'h1);
      end
      s_valid = 1'b0; s_op = 'x;
      cyc(); cyc();
      chk("orn_lat3", m0, 32'hF5F5_F5F5);
      chk("orn_valid", {31'h0, m0v}, 32'h1);
      cyc();
      chk("hold_opx", m0, 32'hF5F5_F5F5);
      chk("hold_opx_valid", {31'h0, m0v}, 32'h0);
      s_valid = 1'b1; s_op = 3'd2; d0a = 32'h00FF_55AA; d0b = 32'hFFFF_0000;
      cyc();
      s_valid = 1'b0; s_op = 'x;
      cyc(); cyc();
      chk("xor_data", m0, 32'hFF00_55AA);
      chk("xor_valid", {31'h0, m0v}, 32'h1);
      cyc();
      chk("xor_hold", m0, 32'hFF00_55AA);
      chk("xor_hold_valid", {31'h0, m0v}, 32'h0);
      s_clear = 1'b1; s_valid = 1'b1; s_op = 3'd1;
      cyc();
      s_clear = 1'b0; s_valid = 1'b0;
      chk("clr_data1", {16'h0, m1}, 32'h0000_3C3C);
      chk("clr_valid1", {31'h0, m1v}, 32'h0);
      cyc(); cyc();
      chk("clr_data0", m0, 32'hFFFF_FFFF);
      chk("clr_valid0", {31'h0, m0v}, 32'h0);
      s_valid = 1'b1; s_op = 3'd0; d0a = 32'hF0F0_F0F0; d0b = 32'h3C3C_3C3C;
      cyc();
      cke = 1'b0; s_op = 3'd5; d0a = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_data", m0, 32'hFFFF_FFFF);
         chk("stall_valid", {31'h0, m0v}, 32'h0);
      end
      cke = 1'b1; s_valid = 1'b0;
      cyc();
      chk("stall_early", m0, 32'hFFFF_FFFF);
      cyc();
      chk("stall_and", m0, 32'h3030_3030);
      chk("stall_and_valid", {31'h0, m0v}, 32'h1);
      s_valid = 1'b1; s_op = 3'd1; d0b = 32'h0;
      for (int k = 0; k < 2; k++) begin
         d0a = {4{8'(8'h11 * (k + 1))}};
         cyc();
      end
      s_valid = 1'b0; reset_n = 1'b0; cke = 1'b0;
      cyc();
      reset_n = 1'b1; cke = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("flush_data", m0, 32'hFFFF_FFFF);
         chk("flush_valid", {31'h0, m0v}, 32'h0);
         cyc();
      end
      s_valid = 1'b1; s_op = 3'd6; d1a = 16'h1234;
      cyc();
      chk("imm_andn", {16'h0, m1}, 32'h0000_1030);
      chk("imm_nox", {31'h0, $isunknown(m1)}, 32'h0);
      s_valid = 1'b0;
      cyc(); cyc(); cyc();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
